intersection_controller: RTL
============================

Name: intersection_controller

Overview:
- Sequences two signal heads at one crossing: main approach A and side approach B. Both heads use the codebase's 3-bit green/yellow/red LED vector.
- A rests in green. B is served only on a side-vehicle or pedestrian request.
- Supports preferential green extension for A, force-red preemption to all-red, and a flashing-yellow attention mode.
- Sits above the per-head LED drivers. All timing is counted in external `tick` pulses (1 tick = 1 s).

Parameters:
- GREEN_A_T, 30, minimum A green length in ticks.
- GREEN_B_T, 20, B green length in ticks.
- YELLOW_T, 3, yellow length in ticks.
- ALLRED_T, 2, all-red clearance in ticks.
- EXT_T, 10, extra A green ticks when preferential is latched.
- FLASH_HALF, 1, ticks per half-period of attention blink.
- Constraint: all values are 1..255, and GREEN_A_T+EXT_T ≤ 255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timing strobe.
- req_b  in  1  side-approach vehicle sensor, level input.
- ped_req  in  1  pedestrian push-button, level or pulse.
- preferential  in  1  extend the next A green by EXT_T.
- force_red  in  1  preemption; drive both heads to red.
- attention  in  1  request flashing-yellow mode.
- leds_a  out  [0:2]  A head: 100 = green, 010 = yellow, 001 = red, 000 = dark.
- leds_b  out  [0:2]  B head, same encoding.
- walk  out  1  pedestrian walk indication.
- phase  out  3  current state code.
- timer  out  8  current phase tick count.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous):
  - State ALL_RED_2, timer=0, leds_a=001, leds_b=001, walk=0, phase=5.
  - All pending latches and the blink bit are cleared.
- State codes:
  - 0 A_GREEN (A=100, B=001)
  - 1 A_YELLOW (A=010, B=001)
  - 2 ALL_RED_1 (001/001)
  - 3 B_GREEN (A=001, B=100, walk=ped_served)
  - 4 B_YELLOW (A=001, B=010)
  - 5 ALL_RED_2 (001/001)
  - 6 HOLD_RED (001/001)
  - 7 FLASH (A=B=010 when blink=1, else 000)
- Timer behaviour:
  - Clears to 0 on every state entry.
  - Increments on each cycle with tick=1.
  - A timed phase of length D ends in the cycle where tick=1 and timer==D-1, so the phase occupies exactly D ticks.
  - The next state and its outputs appear on the following clock edge.
- Pending latches:
  - b_pending is set on any cycle with req_b=1.
  - ped_pending is set on any cycle with ped_req=1.
  - ext_lat is captured from preferential on entry to A_GREEN.
  - On entry to B_GREEN: ped_served <= ped_pending, then both pending latches clear. Requests arriving during B_GREEN are re-latched for the next cycle of the sequence.
- Normal sequence: A_GREEN → A_YELLOW → ALL_RED_1 → B_GREEN → B_YELLOW → ALL_RED_2 → A_GREEN.
- A_GREEN rest rule:
  - Duration DA = GREEN_A_T + (ext_lat ? EXT_T : 0).
  - At the end of DA, with no request pending, the state stays in A_GREEN and the timer saturates at DA-1.
  - From then on, the first cycle in which b_pending or ped_pending is 1 moves to A_YELLOW. No tick is required for this move.
- force_red has the highest priority and is sampled every cycle:
  - In A_GREEN or B_GREEN: go to the matching yellow next cycle (timer=0).
  - In a yellow state: complete the yellow, then the all-red phase.
  - In an all-red state: on completion, go to HOLD_RED instead of the next green.
  - HOLD_RED persists while force_red=1.
  - On release: go to ALL_RED_2 with timer=0, then A_GREEN after ALLRED_T ticks.
- attention has second priority and is honoured only at safe points:
  - In a green state it behaves like force_red until the all-red phase completes.
  - All-red completion goes to FLASH.
  - In HOLD_RED with force_red=0 and attention=1: go to FLASH.
- FLASH:
  - blink toggles after every FLASH_HALF ticks; blink=1 on entry.
  - When attention=0 and force_red=0: go to ALL_RED_2 (timer=0).
  - When force_red=1: go to HOLD_RED.
- Simultaneous events:
  - force_red and attention together → HOLD_RED path.
  - A tick coinciding with a state transition is consumed by the old state.
- walk is 1 only in B_GREEN with ped_served=1, and drops the cycle B_YELLOW is entered.
- A green and a yellow are never shown on both heads at once. Every switch between the heads passes through ≥ ALLRED_T ticks of 001/001.

Test Plan:
- Reset release, tick every 4 cycles, no requests → ALL_RED_2 for 2 ticks, then A_GREEN. After 30 ticks, timer holds at 29 and phase stays 0.
- req_b pulse at A-green tick 10 → A_YELLOW after tick 29 completes, then 3 yellow, 2 all-red, and 20 B-green ticks; walk=0 throughout.
- preferential=1 at A_GREEN entry plus ped_req pulse → A green lasts 40 ticks. B_GREEN then shows walk=1, which drops on entry to B_YELLOW.
- force_red at B-green tick 5 → B_YELLOW next cycle, 3 ticks, ALL_RED_2 for 2 ticks, then HOLD_RED. On release: 2 ticks of all-red, then A_GREEN.
- attention during A_GREEN → yellow then all-red, then FLASH with leds_a = leds_b toggling 010/000 every tick. Attention low → ALL_RED_2, then A_GREEN.
- rst low asynchronously mid-B_YELLOW → outputs go to 001/001, phase=5, timer=0 without waiting for a clock edge. Pending requests are cleared.

Source files
------------

// File: rtl/intersection_controller_if.sv
// Control inputs and signal-head outputs of one intersection_controller.
interface intersection_controller_if;
  logic       tick;
  logic       req_b;
  logic       ped_req;
  logic       preferential;
  logic       force_red;
  logic       attention;
  logic [0:2] leds_a;
  logic [0:2] leds_b;
  logic       walk;
  logic [2:0] phase;
  logic [7:0] timer;

  modport master (
    output tick, req_b, ped_req, preferential, force_red, attention,
    input  leds_a, leds_b, walk, phase, timer
  );

  modport slave (
    input  tick, req_b, ped_req, preferential, force_red, attention,
    output leds_a, leds_b, walk, phase, timer
  );
endinterface

// File: rtl/intersection_controller.sv
// Two-head crossing sequencer: A rests green, B served on request, with
// preemption to all-red and a flashing-yellow attention mode. Timing in ticks.
module intersection_controller #(
  parameter int unsigned GREEN_A_T  = 30,
  parameter int unsigned GREEN_B_T  = 20,
  parameter int unsigned YELLOW_T   = 3,
  parameter int unsigned ALLRED_T   = 2,
  parameter int unsigned EXT_T      = 10,
  parameter int unsigned FLASH_HALF = 1
) (
  input logic                      clk,
  input logic                      rst,
  intersection_controller_if.slave bus
);

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALL_RED_1 = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALL_RED_2 = 3'd5,
    HOLD_RED  = 3'd6,
    FLASH     = 3'd7
  } state_e;

  localparam logic [7:0] GA_L = 8'(GREEN_A_T);
  localparam logic [7:0] GB_L = 8'(GREEN_B_T);
  localparam logic [7:0] Y_L  = 8'(YELLOW_T);
  localparam logic [7:0] AR_L = 8'(ALLRED_T);
  localparam logic [7:0] EX_L = 8'(EXT_T);
  localparam logic [7:0] FH_L = 8'(FLASH_HALF);

  localparam logic [0:2] LED_G = 3'b100;
  localparam logic [0:2] LED_Y = 3'b010;
  localparam logic [0:2] LED_R = 3'b001;
  localparam logic [0:2] LED_D = 3'b000;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       b_pend_q, b_pend_d;
  logic       ped_pend_q, ped_pend_d;
  logic       ext_q, ext_d;
  logic       ped_served_q, ped_served_d;
  logic       blink_q, blink_d;
  logic       sat_q, sat_d;
  logic       frc_q, frc_d;
  logic       attn_q, attn_d;
  logic [0:2] leds_a_q, leds_a_d;
  logic [0:2] leds_b_q, leds_b_d;
  logic       walk_q, walk_d;

  logic [7:0] da;
  logic       stop;
  logic       frc_any;
  logic       attn_any;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    b_pend_d     = b_pend_q | bus.req_b;
    ped_pend_d   = ped_pend_q | bus.ped_req;
    ext_d        = ext_q;
    ped_served_d = ped_served_q;
    blink_d      = blink_q;
    sat_d        = sat_q;
    frc_d        = frc_q;
    attn_d       = attn_q;
    leds_a_d     = LED_R;
    leds_b_d     = LED_R;
    walk_d       = 1'b0;

    da       = GA_L + (ext_q ? EX_L : 8'd0);
    stop     = bus.force_red | bus.attention;
    frc_any  = frc_q | bus.force_red;
    attn_any = attn_q | bus.attention;

    if (bus.tick && timer_q != 8'hFF) timer_d = timer_q + 8'd1;

    // Preemption requests seen anywhere in the normal sequence are held
    // until the next all-red completes.
    if (state_q != HOLD_RED && state_q != FLASH) begin
      frc_d  = frc_any;
      attn_d = attn_any;
    end

    case (state_q)
      A_GREEN: begin
        if (stop) begin
          state_d = A_YELLOW;
        end else if (timer_q == da - 8'd1 && (bus.tick || sat_q)) begin
          timer_d = timer_q;
          if (b_pend_q || ped_pend_q) state_d = A_YELLOW;
          else                        sat_d   = 1'b1;
        end
      end
      A_YELLOW:
        if (bus.tick && timer_q == Y_L - 8'd1) state_d = ALL_RED_1;
      ALL_RED_1:
        if (bus.tick && timer_q == AR_L - 8'd1)
          state_d = frc_any ? HOLD_RED : (attn_any ? FLASH : B_GREEN);
      B_GREEN:
        if (stop || (bus.tick && timer_q == GB_L - 8'd1)) state_d = B_YELLOW;
      B_YELLOW:
        if (bus.tick && timer_q == Y_L - 8'd1) state_d = ALL_RED_2;
      ALL_RED_2:
        if (bus.tick && timer_q == AR_L - 8'd1)
          state_d = frc_any ? HOLD_RED : (attn_any ? FLASH : A_GREEN);
      HOLD_RED:
        if (!bus.force_red) state_d = bus.attention ? FLASH : ALL_RED_2;
      FLASH: begin
        if (bus.force_red) begin
          state_d = HOLD_RED;
        end else if (!bus.attention) begin
          state_d = ALL_RED_2;
        end else if (bus.tick && timer_q == FH_L - 8'd1) begin
          blink_d = ~blink_q;
          timer_d = '0;
        end
      end
      default: state_d = ALL_RED_2;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
      case (state_d)
        A_GREEN: begin
          ext_d = bus.preferential;
          sat_d = 1'b0;
        end
        B_GREEN: begin
          ped_served_d = ped_pend_q;
          b_pend_d     = bus.req_b;
          ped_pend_d   = bus.ped_req;
        end
        HOLD_RED: begin
          frc_d  = 1'b0;
          attn_d = 1'b0;
        end
        FLASH: begin
          frc_d   = 1'b0;
          attn_d  = 1'b0;
          blink_d = 1'b1;
        end
        default: ;
      endcase
    end

    case (state_d)
      A_GREEN:  leds_a_d = LED_G;
      A_YELLOW: leds_a_d = LED_Y;
      B_GREEN: begin
        leds_b_d = LED_G;
        walk_d   = ped_served_d;
      end
      B_YELLOW: leds_b_d = LED_Y;
      FLASH: begin
        leds_a_d = blink_d ? LED_Y : LED_D;
        leds_b_d = blink_d ? LED_Y : LED_D;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ALL_RED_2;
      timer_q      <= '0;
      b_pend_q     <= 1'b0;
      ped_pend_q   <= 1'b0;
      ext_q        <= 1'b0;
      ped_served_q <= 1'b0;
      blink_q      <= 1'b0;
      sat_q        <= 1'b0;
      frc_q        <= 1'b0;
      attn_q       <= 1'b0;
      leds_a_q     <= LED_R;
      leds_b_q     <= LED_R;
      walk_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      b_pend_q     <= b_pend_d;
      ped_pend_q   <= ped_pend_d;
      ext_q        <= ext_d;
      ped_served_q <= ped_served_d;
      blink_q      <= blink_d;
      sat_q        <= sat_d;
      frc_q        <= frc_d;
      attn_q       <= attn_d;
      leds_a_q     <= leds_a_d;
      leds_b_q     <= leds_b_d;
      walk_q       <= walk_d;
    end
  end

  assign bus.leds_a = leds_a_q;
  assign bus.leds_b = leds_b_q;
  assign bus.walk   = walk_q;
  assign bus.phase  = state_q;
  assign bus.timer  = timer_q;

endmodule
